// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// One request in flight at a time; responses return in order.
interface if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_ready, imem_rvalid, imem_rdata
    );
    modport slave (
        input  imem_req, imem_addr,
        output imem_ready, imem_rvalid, imem_rdata
    );
endinterface

// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: one-outstanding imem fetch, 2-entry {PC,instr}
// buffer toward ID, redirect with discard of a stale in-flight response.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    if_stage_if.master  imem,
    output logic        instr_valid,
    output logic [31:0] instrCode,
    output logic [31:0] PC
);
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_ent_t;

    logic [31:0]     pc_q, pc_d;
    logic [31:0]     req_pc_q, req_pc_d;
    logic            outst_q, outst_d;
    logic            drop_q, drop_d;
    logic [1:0]      cnt_q, cnt_d;
    fetch_ent_t [1:0] fifo_q, fifo_d;

    logic       enq, deq, accept;
    logic [1:0] cnt_left;
    fetch_ent_t new_ent;

    assign instr_valid = (cnt_q != 2'd0);
    assign instrCode   = instr_valid ? fifo_q[0].instr : NOP_INSTR;
    assign PC          = instr_valid ? fifo_q[0].pc : 32'd0;

    assign deq      = instr_valid & ~stall;
    assign enq      = imem.imem_rvalid & outst_q & ~drop_q & ~branch_taken;
    assign cnt_left = cnt_q - {1'b0, deq};
    assign new_ent  = '{pc: req_pc_q, instr: imem.imem_rdata};

    // A request only goes out if its response is guaranteed a free slot,
    // counting this cycle's enqueue and dequeue.
    assign imem.imem_req = ~rst & ~branch_taken
                         & (~outst_q | imem.imem_rvalid)
                         & ~(drop_q & ~imem.imem_rvalid)
                         & (({1'b0, cnt_left} + {2'b00, enq}) < 3'd2);
    assign imem.imem_addr = pc_q;
    assign accept         = imem.imem_req & imem.imem_ready;

    always_comb begin
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        outst_d  = outst_q;
        drop_d   = drop_q;
        cnt_d    = cnt_q;
        fifo_d   = fifo_q;
        if (branch_taken) begin
            cnt_d = 2'd0;
            pc_d  = {branch_target[31:2], 2'b00};
            // An unanswered request now belongs to the wrong path.
            if (outst_q & ~imem.imem_rvalid) begin
                drop_d = 1'b1;
            end else begin
                outst_d = 1'b0;
                drop_d  = 1'b0;
            end
        end else begin
            if (accept) begin
                req_pc_d = pc_q;
                pc_d     = pc_q + 32'd4;
                outst_d  = 1'b1;
            end else if (imem.imem_rvalid) begin
                outst_d = 1'b0;
            end
            if (imem.imem_rvalid) drop_d = 1'b0;
            if (deq) fifo_d[0] = fifo_q[1];
            if (enq) begin
                if (cnt_left == 2'd0) fifo_d[0] = new_ent;
                else                  fifo_d[1] = new_ent;
            end
            cnt_d = cnt_left + {1'b0, enq};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            req_pc_q <= 32'd0;
            outst_q  <= 1'b0;
            drop_q   <= 1'b0;
            cnt_q    <= 2'd0;
            fifo_q   <= '0;
        end else begin
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            outst_q  <= outst_d;
            drop_q   <= drop_d;
            cnt_q    <= cnt_d;
            fifo_q   <= fifo_d;
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: variable-latency imem model, scoreboard of responses
// that must reach ID, directed startup/stall/redirect/backpressure/reset cases.
module tb_if_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        instr_valid;
    logic [31:0] instrCode, PC;

    if_stage_if bus();

    if_stage dut (
        .clk(clk), .rst(rst), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem(bus),
        .instr_valid(instr_valid), .instrCode(instrCode), .PC(PC)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    // imem model: fixed latency, one pending request, not ready while busy.
    int          lat = 1;
    logic        ready_en = 1'b1;
    logic        mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = 32'd0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC3A5_0000;
    endfunction

    assign bus.imem_rvalid = mem_busy && (mem_cnt == 0);
    assign bus.imem_rdata  = bus.imem_rvalid ? mem_word(mem_addr) : 32'hDEAD_BEEF;
    assign bus.imem_ready  = ready_en && !(mem_busy && !bus.imem_rvalid);

    always @(posedge clk) begin
        if (bus.imem_rvalid) mem_busy <= 1'b0;
        else if (mem_busy)   mem_cnt  <= mem_cnt - 1;
        if (bus.imem_req && bus.imem_ready) begin
            mem_busy <= 1'b1;
            mem_cnt  <= lat - 1;
            mem_addr <= bus.imem_addr;
        end
    end

    // Scoreboard: responses to live requests are pushed; each ID dequeue pops.
    logic [63:0] sb[$];
    logic [31:0] exp_pc = 32'd0;
    logic        stale = 1'b0;
    int          pops = 0;

    always @(negedge clk) begin
        logic [63:0] e;
        if (rst) begin
            sb.delete();
            exp_pc = 32'd0;
            stale  = mem_busy && !bus.imem_rvalid;
        end else begin
            if (instr_valid && !stall) begin
                chk("sb_nonempty", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("sb_pc", PC, e[63:32]);
                    chk("sb_instr", instrCode, e[31:0]);
                end
                chk("pc_seq", PC, exp_pc);
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            if (branch_taken) begin
                sb.delete();
                exp_pc = {branch_target[31:2], 2'b00};
                if (mem_busy && !bus.imem_rvalid) stale = 1'b1;
                else if (bus.imem_rvalid)         stale = 1'b0;
            end else if (bus.imem_rvalid) begin
                if (!stale) sb.push_back({mem_addr, bus.imem_rdata});
                stale = 1'b0;
            end
        end
    end

    // sel: 0 = request to addr a accepted, 1 = instr_valid, 2 = imem_rvalid
    task automatic wait_sig(input string tag, input int sel, input logic [31:0] a, input int budget);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            case (sel)
                0:       hit = bus.imem_req && bus.imem_ready && (bus.imem_addr == a);
                1:       hit = instr_valid;
                default: hit = bus.imem_rvalid;
            endcase
        end
        chk(tag, 32'(hit), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset and startup, 1-cycle memory
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(bus.imem_req), 0);
        chk("rst_vld", 32'(instr_valid), 0);
        chk("rst_code", instrCode, NOP);
        chk("rst_pc", PC, 0);
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("su_req", 32'(bus.imem_req), 1);
            chk("su_addr", bus.imem_addr, 4 * k);
            if (k == 1) begin
                chk("su_rvalid", 32'(bus.imem_rvalid), 1);
                chk("su_vld_early", 32'(instr_valid), 0);
            end
            if (k >= 2) begin
                chk("su_vld", 32'(instr_valid), 1);
                chk("su_pc", PC, 4 * (k - 2));
            end
        end

        // stall hold: head is PC 0x10 for the whole stall, fetch stops when full
        @(posedge clk); #1 stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("st_vld", 32'(instr_valid), 1);
            chk("st_pc", PC, 32'h10);
            chk("st_code", instrCode, mem_word(32'h10));
            if (k >= 1) chk("st_req", 32'(bus.imem_req), 0);
        end
        @(posedge clk); #1 stall = 1'b0;
        repeat (6) @(negedge clk);

        // redirect with nothing in flight
        @(posedge clk); #1 stall = 1'b1;
        repeat (3) @(negedge clk);
        chk("rd0_idle_req", 32'(bus.imem_req), 0);
        @(posedge clk); #1 branch_taken = 1'b1; branch_target = 32'h0000_0103;
        @(posedge clk); #1 branch_taken = 1'b0; stall = 1'b0;
        @(negedge clk);
        chk("rd0_vld", 32'(instr_valid), 0);
        chk("rd0_addr", bus.imem_addr, 32'h100);
        chk("rd0_req", 32'(bus.imem_req), 1);
        wait_sig("rd0_wait", 1, 32'd0, 10);
        chk("rd0_pc", PC, 32'h100);

        // backpressure: address holds while not accepted
        repeat (3) @(negedge clk);
        @(posedge clk); #1 ready_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_req", 32'(bus.imem_req), 1);
            chk("bp_addr", bus.imem_addr, 32'h118);
        end
        @(posedge clk); #1 ready_en = 1'b1;
        @(negedge clk);
        chk("bp_acc_addr", bus.imem_addr, 32'h118);
        @(negedge clk);
        chk("bp_next_addr", bus.imem_addr, 32'h11C);

        // redirect while a 3-cycle fetch of 0x10 is outstanding
        @(posedge clk); #1 rst = 1'b1; lat = 3;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        wait_sig("rd1_acc10", 0, 32'h10, 80);
        @(posedge clk); #1 branch_taken = 1'b1; branch_target = 32'h0000_0200;
        @(posedge clk); #1 branch_taken = 1'b0;
        @(negedge clk);
        chk("rd1_drop_req", 32'(bus.imem_req), 0);
        chk("rd1_vld", 32'(instr_valid), 0);
        wait_sig("rd1_stale", 2, 32'd0, 10);
        chk("rd1_reissue_req", 32'(bus.imem_req), 1);
        chk("rd1_reissue_addr", bus.imem_addr, 32'h200);
        wait_sig("rd1_wait", 1, 32'd0, 20);
        chk("rd1_pc", PC, 32'h200);

        // async reset between edges with a fetch in flight
        @(posedge clk); #1 stall = 1'b1;
        wait_sig("ar_wait", 1, 32'd0, 20);
        chk("ar_held_pc", PC, 32'h204);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        chk("ar_vld", 32'(instr_valid), 0);
        chk("ar_code", instrCode, NOP);
        chk("ar_pc", PC, 0);
        chk("ar_req", 32'(bus.imem_req), 0);
        @(negedge clk); #1 rst = 1'b0; stall = 1'b0;
        @(negedge clk);
        chk("ar_restart_req", 32'(bus.imem_req), 1);
        chk("ar_restart_addr", bus.imem_addr, 32'h0);
        wait_sig("ar_first_wait", 1, 32'd0, 30);
        chk("ar_first_pc", PC, 32'h0);

        repeat (10) @(negedge clk);
        chk("pops", 32'(pops > 15), 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined RV32I core. It is the producer side of the IF/ID interface that the ID stage consumes (instrCode, PC).
- Generates word-aligned fetch addresses and issues requests to instruction memory over a request/response handshake.
- Buffers returned instructions with their PCs in a 2-entry FIFO and presents them to ID under stall control.
- Handles taken-branch/jump redirects, including discarding a stale in-flight response.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, value driven on instrCode when no valid instruction is presented (ADDI x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  ID cannot accept this cycle; hold the presented instruction.
- branch_taken  in  1  single-cycle redirect pulse from EX.
- branch_target  in  32  redirect PC; bits [1:0] are ignored (forced to 0).
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address; equals fetch PC register pc_q.
- imem_ready  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response data valid; in order, latency ≥1 cycle.
- imem_rdata  in  32  returned instruction word.
- instr_valid  out  1  instrCode/PC hold a valid instruction for ID.
- instrCode  out  32  FIFO head instruction; NOP_INSTR when instr_valid=0.
- PC  out  32  PC of the FIFO head; 0 when instr_valid=0.

Behaviour:
- Reset (asynchronous, while rst=1):
  - pc_q=RESET_PC, FIFO count=0, outstanding=0, drop=0.
  - imem_req=0, instr_valid=0, instrCode=NOP_INSTR, PC=0.
  - First imem_req is asserted in the first cycle after rst deasserts.
- Dequeue: deq = instr_valid & ~stall. Dequeue pops the head at the clock edge; the next entry (if any) appears the following cycle.
- Enqueue: enq = imem_rvalid & outstanding & ~drop & ~branch_taken. Pushes {req_pc, imem_rdata}.
- Outstanding limit:
  - At most one request in flight.
  - A request may issue in the same cycle its predecessor's response returns.
- Request issue:
  - imem_req = ~branch_taken & (~outstanding | imem_rvalid) & ~(drop & ~imem_rvalid) & (count + enq − deq < 2).
  - Request accepted when imem_req & imem_ready:
    - req_pc <= pc_q
    - pc_q <= pc_q + 4 (wraps modulo 2^32)
    - outstanding <= 1
  - Response with no new accept: outstanding <= 0.
  - imem_req may stay high across cycles with imem_ready=0. imem_addr must stay stable until accepted.
- Throughput: with 1-cycle memory latency and stall=0, steady state is 1 instruction/cycle.
- Redirect (branch_taken=1), highest priority:
  - FIFO flushed (count <= 0); instr_valid=0 from the next cycle.
  - pc_q <= {branch_target[31:2],2'b00}.
  - No request issued this cycle.
  - A same-cycle imem_rvalid is discarded.
  - If a request is outstanding and its response has not returned this cycle, set drop=1.
- Drop state:
  - The next imem_rvalid is discarded and clears drop and outstanding.
  - A new request to the target may issue in that same cycle.
- Redirect during drop: drop stays 1; pc_q is updated to the newest target.
- Simultaneous dequeue and enqueue at count=2 is impossible: the request-issue gate guarantees space.
- Stall with FIFO full: no further requests; outputs hold.
- Reset mid-transaction: all state is cleared. A response arriving after reset release with outstanding=0 is ignored.

Test Plan:
- Reset/startup: rst high 2 cycles, 1-cycle imem, stall=0 → imem_addr 0x0,0x4,0x8... on consecutive cycles; instr_valid rises the cycle after the first rvalid; PC/instrCode pairs match addresses; 1 instruction/cycle.
- Stall hold: stall=1 for 4 cycles with the FIFO filling → at most 2 buffered, imem_req drops; instrCode/PC constant; release → remaining entries drain in order, with no duplicate or lost PC.
- Redirect, no in-flight request: branch_taken with target 0x0000_0103 → FIFO flushed; next imem_addr=0x0000_0100; next presented PC=0x100.
- Redirect, in-flight stale response: 3-cycle memory, redirect to 0x200 while the fetch of 0x10 is outstanding → the 0x10 data is never presented; first valid PC=0x200.
- Backpressure: imem_ready=0 for 3 cycles → imem_addr is stable and pc_q does not advance; accept → normal sequence resumes.
- Async reset mid-operation: rst pulse between edges during outstanding fetch → outputs reset immediately (instrCode=0x00000013, instr_valid=0); the late rvalid is ignored; fetch restarts at RESET_PC.
